softmax_max_sub: RTL

SOFTMAX_MAX_SUB -- requirements
Module: softmax_max_sub

---
 rtl/softmax_max_sub.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/softmax_max_sub.sv
// Two-pass softmax front end: scans a FIFO-held vector for its signed maximum,
// then rewinds the FIFO and streams out (element - max) at one extra bit of width.
module softmax_max_sub #(
   parameter int DATA_WIDTH = 16,
   parameter int VEC_LEN    = 7,
   parameter int CNT_WIDTH  = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic signed [DATA_WIDTH-1:0] data_in_fifo,
   output logic                         rd_en,
   output logic                         rd_inc,
   output logic                         rd_clr,
   output logic                         busy,
   output logic signed [DATA_WIDTH-1:0] max_val,
   output logic signed [DATA_WIDTH:0]   diff_out,
   output logic                         diff_valid,
   output logic                         done
);

   typedef enum logic [2:0] {
      IDLE,
      REWIND1,
      SCAN,
      DRAIN1,
      REWIND2,
      SUB,
      DRAIN2,
      DONE
   } state_t;

   localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [CNT_WIDTH-1:0]         LAST_CNT = CNT_WIDTH'(VEC_LEN - 1);

   // One extra bit keeps max-to-min differences exact without wrapping.
   function automatic logic signed [DATA_WIDTH:0] sub_wide(
      input logic signed [DATA_WIDTH-1:0] a,
      input logic signed [DATA_WIDTH-1:0] b
   );
      return {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
   endfunction

   function automatic logic is_greater(
      input logic signed [DATA_WIDTH-1:0] a,
      input logic signed [DATA_WIDTH-1:0] b
   );
      return a > b;
   endfunction

   state_t                         state_q, state_d;
   logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
   logic                           vld_p1_q, vld_p1_d;
   logic signed [DATA_WIDTH-1:0]   max_q, max_d;
   logic signed [DATA_WIDTH:0]     diff_p2_q, diff_p2_d;
   logic                           vld_p2_q, vld_p2_d;
   logic                           scan_phase;
   logic                           sub_phase;

   always_comb begin
      rd_en  = (state_q == SCAN) || (state_q == SUB);
      rd_inc = rd_en;
      rd_clr = (state_q == REWIND1) || (state_q == REWIND2);
      busy   = (state_q != IDLE);
      done   = (state_q == DONE);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = REWIND1;
         end
         REWIND1: begin
            cnt_d   = '0;
            state_d = SCAN;
         end
         SCAN: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               state_d = DRAIN1;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         DRAIN1:  state_d = REWIND2;
         REWIND2: begin
            cnt_d   = '0;
            state_d = SUB;
         end
         SUB: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               state_d = DRAIN2;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         DRAIN2:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Stage p1: FIFO data lands one cycle after rd_en; vld_p1 qualifies it.
   always_comb begin
      scan_phase = (state_q == SCAN) || (state_q == DRAIN1);
      sub_phase  = (state_q == SUB) || (state_q == DRAIN2);
      vld_p1_d   = rd_en;
      max_d      = max_q;
      if (state_q == REWIND1) begin
         max_d = MOST_NEG;
      end else if (scan_phase && vld_p1_q && is_greater(data_in_fifo, max_q)) begin
         max_d = data_in_fifo;
      end
   end

   // Stage p2: registered difference and its qualifier.
   always_comb begin
      diff_p2_d = diff_p2_q;
      vld_p2_d  = 1'b0;
      if (sub_phase && vld_p1_q) begin
         diff_p2_d = sub_wide(data_in_fifo, max_q);
         vld_p2_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         vld_p1_q  <= 1'b0;
         max_q     <= '0;
         diff_p2_q <= '0;
         vld_p2_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         vld_p1_q  <= vld_p1_d;
         max_q     <= max_d;
         diff_p2_q <= diff_p2_d;
         vld_p2_q  <= vld_p2_d;
      end
   end

   assign max_val    = max_q;
   assign diff_out   = diff_p2_q;
   assign diff_valid = vld_p2_q;

endmodule
